nem_ohmux_sel_ctrl: RTL

//   Sequencer/arbiter for the 2-input one-hot NEM relay mux (selects S0/S1).
//   Two requesters share the mux output. The block grants one at a time and

---
 rtl/nem_ohmux_sel_ctrl.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/nem_ohmux_sel_ctrl.sv
// Select sequencer for the 2-input one-hot NEM relay mux.
// Two requesters share ZN. The block grants one side at a time and drives S0/S1 one-hot.
// It enforces break-before-make dead time and relay settle time before the output is
// declared valid, and it preempts a long-held grant when the other side is waiting.
module nem_ohmux_sel_ctrl #(
  parameter int unsigned DEAD_CYC   = 2,
  parameter int unsigned SETTLE_CYC = 4,
  parameter int unsigned MAX_HOLD   = 8
) (
  input  logic CP,
  input  logic CDN,
  input  logic REQ0,
  input  logic REQ1,
  output logic GNT0,
  output logic GNT1,
  output logic S0,
  output logic S1,
  output logic ZN_VLD,
  output logic BUSY
);

  localparam int unsigned MaxDs    = (DEAD_CYC > SETTLE_CYC) ? DEAD_CYC : SETTLE_CYC;
  localparam int unsigned MaxParam = (MaxDs > MAX_HOLD) ? MaxDs : MAX_HOLD;
  localparam int unsigned CntW     = $clog2(MaxParam) + 1;

  localparam logic [CntW-1:0] DeadLast   = CntW'(DEAD_CYC - 1);
  localparam logic [CntW-1:0] SettleLast = CntW'(SETTLE_CYC - 1);
  localparam logic [CntW-1:0] HoldMax    = CntW'(MAX_HOLD);
  localparam logic [CntW-1:0] CntOne     = CntW'(1);
  localparam logic [CntW-1:0] CntZero    = '0;

  typedef enum logic [1:0] {StIdle, StSettle, StGrant, StDead} state_e;

  state_e          state_q;
  logic            owner_q;   // 0: requester 0 owns the mux, 1: requester 1
  logic            lg_q;      // last requester that reached GRANT; loses the next tie
  logic [CntW-1:0] cnt_q;     // settle / dead-time counter
  logic [CntW-1:0] hold_q;    // grant cycles elapsed, including the current one

  logic req_any;
  logic req_own;
  logic req_oth;
  logic win;

  // Request views relative to the current owner, and the arbitration winner
  always_comb begin
    req_any = REQ0 | REQ1;
    req_own = owner_q ? REQ1 : REQ0;
    req_oth = owner_q ? REQ0 : REQ1;
    if (REQ0 && REQ1) begin
      win = ~lg_q;
    end else begin
      win = REQ1;
    end
  end

  // Sequencer FSM; all outputs are registered alongside the state
  always_ff @(posedge CP or negedge CDN) begin
    if (!CDN) begin
      state_q <= StIdle;
      owner_q <= 1'b0;
      lg_q    <= 1'b1;
      cnt_q   <= CntZero;
      hold_q  <= CntZero;
      S0      <= 1'b0;
      S1      <= 1'b0;
      GNT0    <= 1'b0;
      GNT1    <= 1'b0;
      ZN_VLD  <= 1'b0;
      BUSY    <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (req_any) begin
            state_q <= StSettle;
            owner_q <= win;
            cnt_q   <= CntZero;
            S0      <= ~win;
            S1      <= win;
            BUSY    <= 1'b1;
          end
        end

        StSettle: begin
          if (!req_own) begin
            // Owner gave up before the relay settled: release without a grant
            state_q <= StDead;
            cnt_q   <= CntZero;
            S0      <= 1'b0;
            S1      <= 1'b0;
          end else if (cnt_q == SettleLast) begin
            state_q <= StGrant;
            hold_q  <= CntOne;
            lg_q    <= owner_q;
            GNT0    <= ~owner_q;
            GNT1    <= owner_q;
            ZN_VLD  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end

        StGrant: begin
          if (!req_own || (req_oth && (hold_q == HoldMax))) begin
            state_q <= StDead;
            cnt_q   <= CntZero;
            S0      <= 1'b0;
            S1      <= 1'b0;
            GNT0    <= 1'b0;
            GNT1    <= 1'b0;
            ZN_VLD  <= 1'b0;
          end else if (hold_q != HoldMax) begin
            hold_q <= hold_q + CntOne;
          end
        end

        StDead: begin
          if (cnt_q == DeadLast) begin
            if (req_any) begin
              state_q <= StSettle;
              owner_q <= win;
              cnt_q   <= CntZero;
              S0      <= ~win;
              S1      <= win;
            end else begin
              state_q <= StIdle;
              BUSY    <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end

        default: begin
          state_q <= StIdle;
          S0      <= 1'b0;
          S1      <= 1'b0;
          GNT0    <= 1'b0;
          GNT1    <= 1'b0;
          ZN_VLD  <= 1'b0;
          BUSY    <= 1'b0;
        end
      endcase
    end
  end

endmodule
